// File: rtl/msk_ciphertext_unloader_pkg.sv
// Shared constants and types for the masked ciphertext unloader.
// WORDS_PER_BLOCK / WORD_BITS describe how a 128-bit block is split into
// 32-bit words. The FSM encoding is EMPTY (nothing held) and DRAIN
// (a block is held and being streamed out).
package msk_ciphertext_unloader_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_BITS       = 32;
  localparam int BLOCK_BITS      = WORDS_PER_BLOCK * WORD_BITS;

  // Index of the final word of a block.
  localparam logic [1:0] LAST_WIDX = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/msk_ciphertext_unloader.sv
// Masked ciphertext unloader.
// Accepts one shared ciphertext block from the AES core and streams it as
// four shared 32-bit words. Shares are never recombined here.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   cipher_valid  core ciphertext valid
//   out_ready     ready towards the core
//   sh_ciphertext shared ciphertext, shbus encoding (bit i of share j at d*i+j)
//   word_valid    output word valid
//   word_ready    downstream ready
//   sh_word       shared output word, shbus encoding
//   word_last     marks the 4th word of a block
//   busy          a captured block is not yet fully drained
module msk_ciphertext_unloader
  import msk_ciphertext_unloader_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cipher_valid,
  output logic                       out_ready,
  input  logic [BLOCK_BITS*d-1:0]    sh_ciphertext,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [WORD_BITS*d-1:0]     sh_word,
  output logic                       word_last,
  output logic                       busy
);

  // In shbus encoding the d shares of 32 consecutive plaintext bits are
  // contiguous, so word k is simply the k-th WORD_W slice of the buffer.
  localparam int WORD_W = WORD_BITS * d;
  localparam int BUF_W  = BLOCK_BITS * d;

  state_e             state_r;
  state_e             state_nxt_s;
  logic [1:0]         widx_r;
  logic [1:0]         widx_nxt_s;
  logic [BUF_W-1:0]   sh_buf_r;
  logic [BUF_W-1:0]   sh_buf_nxt_s;
  logic               capture_s;
  logic               word_hs_s;

  // State, word index and share buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= EMPTY;
      widx_r   <= 2'd0;
      sh_buf_r <= {BUF_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      widx_r   <= widx_nxt_s;
      sh_buf_r <= sh_buf_nxt_s;
    end
  end

  // Next-state logic: capture has priority over the final-word release so
  // a new block can be loaded in the same cycle without a bubble.
  always_comb begin
    state_nxt_s  = state_r;
    widx_nxt_s   = widx_r;
    sh_buf_nxt_s = sh_buf_r;
    capture_s    = cipher_valid & out_ready;
    word_hs_s    = word_valid & word_ready;
    case (state_r)
      EMPTY: begin
        if (capture_s) begin
          state_nxt_s  = DRAIN;
          widx_nxt_s   = 2'd0;
          sh_buf_nxt_s = sh_ciphertext;
        end else begin
          state_nxt_s  = EMPTY;
        end
      end
      DRAIN: begin
        if (capture_s) begin
          state_nxt_s  = DRAIN;
          widx_nxt_s   = 2'd0;
          sh_buf_nxt_s = sh_ciphertext;
        end else if (word_hs_s) begin
          if (widx_r == LAST_WIDX) begin
            // Zeroise so no stale shares linger after the block leaves.
            state_nxt_s  = EMPTY;
            widx_nxt_s   = 2'd0;
            sh_buf_nxt_s = {BUF_W{1'b0}};
          end else begin
            widx_nxt_s   = widx_r + 2'd1;
          end
        end else begin
          state_nxt_s  = DRAIN;
        end
      end
      default: begin
        state_nxt_s  = EMPTY;
        widx_nxt_s   = 2'd0;
        sh_buf_nxt_s = {BUF_W{1'b0}};
      end
    endcase
  end

  // Output decode. out_ready depends only on registered state and
  // word_ready, never on cipher_valid. sh_word is a pure mux of registers,
  // so it cannot glitch while the index is held during a stall.
  always_comb begin
    word_valid = 1'b0;
    word_last  = 1'b0;
    busy       = 1'b0;
    out_ready  = 1'b1;
    case (state_r)
      EMPTY: begin
        word_valid = 1'b0;
        word_last  = 1'b0;
        busy       = 1'b0;
        out_ready  = 1'b1;
      end
      DRAIN: begin
        word_valid = 1'b1;
        busy       = 1'b1;
        word_last  = (widx_r == LAST_WIDX);
        out_ready  = (widx_r == LAST_WIDX) & word_ready;
      end
      default: begin
        word_valid = 1'b0;
        word_last  = 1'b0;
        busy       = 1'b0;
        out_ready  = 1'b1;
      end
    endcase
    case (widx_r)
      2'd0:    sh_word = sh_buf_r[0*WORD_W +: WORD_W];
      2'd1:    sh_word = sh_buf_r[1*WORD_W +: WORD_W];
      2'd2:    sh_word = sh_buf_r[2*WORD_W +: WORD_W];
      2'd3:    sh_word = sh_buf_r[3*WORD_W +: WORD_W];
      default: sh_word = {WORD_W{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_msk_ciphertext_unloader.sv
// Self-checking bench for msk_ciphertext_unloader (d=2 and d=3 instances).
module tb_msk_ciphertext_unloader;

  logic         clk = 1'b0;
  logic         rst;
  logic         cv2, ordy2, wv2, wr2, wl2, busy2;
  logic [255:0] ct2;
  logic [63:0]  sw2;
  logic         cv3, ordy3, wv3, wr3, wl3, busy3;
  logic [383:0] ct3;
  logic [95:0]  sw3;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] plain;
    logic [95:0] raw;
  } exp_t;

  typedef struct {
    logic        cv;
    logic        wr;
    logic        e_wv;
    logic        e_wl;
    logic        e_ordy;
    logic [31:0] e_word;
  } vec_t;

  exp_t q2[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  msk_ciphertext_unloader #(.d(2)) dut2 (
    .clk(clk), .rst(rst), .cipher_valid(cv2), .out_ready(ordy2),
    .sh_ciphertext(ct2), .word_valid(wv2), .word_ready(wr2),
    .sh_word(sw2), .word_last(wl2), .busy(busy2)
  );

  msk_ciphertext_unloader #(.d(3)) dut3 (
    .clk(clk), .rst(rst), .cipher_valid(cv3), .out_ready(ordy3),
    .sh_ciphertext(ct3), .word_valid(wv3), .word_ready(wr3),
    .sh_word(sw3), .word_last(wl3), .busy(busy3)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 128'(act), 128'(exp));
  endtask

  // Build the shbus image of a block from the plain value and the masks.
  function automatic logic [383:0] enc_block(input logic [127:0] ct, input logic [127:0] m1,
                                             input logic [127:0] m2, input int d);
    logic [127:0] s0;
    logic [383:0] r;
    s0 = ct ^ m1 ^ ((d == 3) ? m2 : 128'd0);
    r  = '0;
    for (int i = 0; i < 128; i++) begin
      r[d*i]   = s0[i];
      r[d*i+1] = m1[i];
      if (d == 3) r[d*i+2] = m2[i];
    end
    return r;
  endfunction

  function automatic logic [95:0] enc_word(input logic [31:0] w, input logic [31:0] m1,
                                           input logic [31:0] m2, input int d);
    logic [31:0] s0;
    logic [95:0] r;
    s0 = w ^ m1 ^ ((d == 3) ? m2 : 32'd0);
    r  = '0;
    for (int i = 0; i < 32; i++) begin
      r[d*i]   = s0[i];
      r[d*i+1] = m1[i];
      if (d == 3) r[d*i+2] = m2[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] recombine(input logic [95:0] w, input int d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < d; j++)
        r[i] = r[i] ^ w[d*i+j];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] fips, ca, cb, ma, mb, rc2, rm2, rc3, rm3a, rm3b;
  logic [383:0] tmp;
  logic [63:0]  prev2;
  logic [95:0]  prev3;
  logic         stall2, stall3, ordy_e, offer;
  logic [31:0]  ew;
  exp_t         e;
  vec_t         tbl[7];
  int unsigned  seed_val;

  initial begin
    seed_val = $urandom(1);
    rst = 1'b1;
    cv2 = 1'b0; wr2 = 1'b0; ct2 = '0;
    cv3 = 1'b0; wr3 = 1'b0; ct3 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_wv2", wv2, 1'b0);     chk1("rst_wl2", wl2, 1'b0);
    chk1("rst_busy2", busy2, 1'b0); chk1("rst_ordy2", ordy2, 1'b1);
    chk("rst_sw2", 128'(sw2), 128'd0);
    chk1("rst_buf2", |dut2.sh_buf_r, 1'b0);
    chk1("rst_ordy3", ordy3, 1'b1); chk("rst_sw3", 128'(sw3), 128'd0);
    rst = 1'b0;

    // FIPS-197 single block with one stall on the last word
    fips = {32'h320b6a19, 32'h978511dc, 32'hfb09dc02, 32'h1d842539};
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1d842539};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hfb09dc02};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h978511dc};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h320b6a19};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h320b6a19};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    tmp = enc_block(fips, 128'd0, 128'd0, 2);
    for (int r = 0; r < 7; r++) begin
      @(negedge clk);
      cv2 = tbl[r].cv; wr2 = tbl[r].wr; ct2 = tmp[255:0];
      #1;
      chk1("tbl_wv", wv2, tbl[r].e_wv);
      chk1("tbl_busy", busy2, tbl[r].e_wv);
      chk1("tbl_wl", wl2, tbl[r].e_wl);
      chk1("tbl_ordy", ordy2, tbl[r].e_ordy);
      chk("tbl_word", 128'(recombine(96'(sw2), 2)), 128'(tbl[r].e_word));
    end
    // Zeroisation after the last handshake
    chk1("zero_buf", |dut2.sh_buf_r, 1'b0);
    chk("zero_word", 128'(sw2), 128'd0);

    // Back-to-back blocks with cipher_valid held high
    ca = rnd128(); cb = rnd128(); ma = rnd128() | 128'd1; mb = rnd128() | 128'd2;
    @(negedge clk);
    tmp = enc_block(ca, ma, 128'd0, 2);
    cv2 = 1'b1; wr2 = 1'b1; ct2 = tmp[255:0];
    #1;
    chk1("b2b_ordy0", ordy2, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tmp = enc_block(cb, mb, 128'd0, 2);
      ct2 = tmp[255:0];
      if (k == 4) cv2 = 1'b0;
      #1;
      ew = (k < 4) ? ca[32*k +: 32] : cb[32*(k-4) +: 32];
      chk1("b2b_wv", wv2, 1'b1);
      chk("b2b_word", 128'(recombine(96'(sw2), 2)), 128'(ew));
      chk("b2b_raw", 128'(sw2), 128'(enc_word(ew, (k < 4) ? ma[32*k +: 32] : mb[32*(k-4) +: 32], 32'd0, 2)));
      chk1("b2b_wl", wl2, (k % 4) == 3);
      chk1("b2b_ordy", ordy2, (k % 4) == 3);
    end
    @(negedge clk);
    #1;
    chk1("b2b_idle", wv2, 1'b0);

    // Reset mid-drain after words 0 and 1
    @(negedge clk);
    tmp = enc_block(ca, ma, 128'd0, 2);
    cv2 = 1'b1; ct2 = tmp[255:0]; wr2 = 1'b1;
    @(negedge clk);
    cv2 = 1'b0;
    #1;
    chk("rmd_w0", 128'(recombine(96'(sw2), 2)), 128'(ca[31:0]));
    @(negedge clk);
    #1;
    chk("rmd_w1", 128'(recombine(96'(sw2), 2)), 128'(ca[63:32]));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk1("rmd_wv", wv2, 1'b0);     chk1("rmd_busy", busy2, 1'b0);
    chk1("rmd_ordy", ordy2, 1'b1); chk1("rmd_buf", |dut2.sh_buf_r, 1'b0);
    chk("rmd_sw", 128'(sw2), 128'd0);
    rst = 1'b0;
    tmp = enc_block(cb, mb, 128'd0, 2);
    cv2 = 1'b1; ct2 = tmp[255:0];
    @(negedge clk);
    cv2 = 1'b0;
    #1;
    chk("rmd_new_w0", 128'(recombine(96'(sw2), 2)), 128'(cb[31:0]));
    chk1("rmd_new_wl", wl2, 1'b0);
    repeat (4) @(negedge clk);

    // Randomised traffic with backpressure against a queue model, d=2 and d=3
    stall2 = 1'b0; stall3 = 1'b0; prev2 = '0; prev3 = '0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(negedge clk);
      offer = (cyc < 400);
      rc2 = rnd128(); rm2 = rnd128(); if (rm2 == 128'd0) rm2 = 128'd1;
      rc3 = rnd128(); rm3a = rnd128(); rm3b = rnd128();
      if (rm3a == 128'd0) rm3a = 128'd1;
      if (rm3b == 128'd0) rm3b = 128'd1;
      cv2 = offer && ($urandom_range(0, 3) != 0);
      cv3 = offer && ($urandom_range(0, 3) != 0);
      wr2 = 1'($urandom_range(0, 1));
      wr3 = 1'($urandom_range(0, 1));
      tmp = enc_block(rc2, rm2, 128'd0, 2); ct2 = tmp[255:0];
      ct3 = enc_block(rc3, rm3a, rm3b, 3);
      #1;
      // d=2 instance
      ordy_e = (q2.size() == 0) || (q2.size() == 1 && wr2);
      chk1("rnd2_wv", wv2, q2.size() != 0);
      chk1("rnd2_busy", busy2, q2.size() != 0);
      chk1("rnd2_wl", wl2, q2.size() == 1);
      chk1("rnd2_ordy", ordy2, ordy_e);
      if (stall2) chk("rnd2_stall", 128'(sw2), 128'(prev2));
      if (q2.size() != 0 && wr2) begin
        e = q2.pop_front();
        chk("rnd2_word", 128'(recombine(96'(sw2), 2)), 128'(e.plain));
        chk("rnd2_raw", 128'(sw2), 128'(e.raw[63:0]));
      end
      if (cv2 && ordy_e) begin
        for (int k = 0; k < 4; k++) begin
          e.plain = rc2[32*k +: 32];
          e.raw   = enc_word(rc2[32*k +: 32], rm2[32*k +: 32], 32'd0, 2);
          q2.push_back(e);
        end
      end
      stall2 = wv2 && !wr2; prev2 = sw2;
      // d=3 instance
      ordy_e = (q3.size() == 0) || (q3.size() == 1 && wr3);
      chk1("rnd3_wv", wv3, q3.size() != 0);
      chk1("rnd3_wl", wl3, q3.size() == 1);
      chk1("rnd3_ordy", ordy3, ordy_e);
      if (stall3) chk("rnd3_stall", 128'(sw3), 128'(prev3));
      if (q3.size() != 0 && wr3) begin
        e = q3.pop_front();
        chk("rnd3_word", 128'(recombine(sw3, 3)), 128'(e.plain));
        chk("rnd3_raw", 128'(sw3), 128'(e.raw));
      end
      if (cv3 && ordy_e) begin
        for (int k = 0; k < 4; k++) begin
          e.plain = rc3[32*k +: 32];
          e.raw   = enc_word(rc3[32*k +: 32], rm3a[32*k +: 32], rm3b[32*k +: 32], 3);
          q3.push_back(e);
        end
      end
      stall3 = wv3 && !wr3; prev3 = sw3;
    end
    chk1("rnd_drained2", q2.size() == 0, 1'b1);
    chk1("rnd_drained3", q3.size() == 0, 1'b1);
    chk1("rnd_zero_buf3", |dut3.sh_buf_r, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
